vid_dbg_capture_ctrl: RTL and testbench

Run controller for the video debug module's frame-size error checker. It holds the checker in reset until armed, flushes it, and releases it aligned to a start-of-frame beat. It then monitors a programmed number of frames and snapshots the stream position and error type of the first error. It sits between the AXI-Lite register bank and the checker, and drives the checker's resetn.

---
 rtl/vid_dbg_pkg.sv | 36 +++
 rtl/vid_dbg_capture_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_vid_dbg_capture_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vid_dbg_pkg
// Description : Shared definitions for the video debug capture controller:
//               state encodings, err_vec bit positions and the width
//               helpers used to size the stream position counters.
// Revision    : 1.0 - initial release
// ============================================================================
package vid_dbg_pkg;

    // Run-controller state encoding (also driven out on the state port)
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FLUSH     = 3'd1;
    localparam logic [2:0] ST_WAIT_SOF  = 3'd2;
    localparam logic [2:0] ST_MONITOR   = 3'd3;
    localparam logic [2:0] ST_TRIGGERED = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    // Bit positions inside the checker's err_vec
    localparam int EOL_EARLY = 0;
    localparam int EOL_LATE  = 1;
    localparam int SOF_EARLY = 2;
    localparam int SOF_LATE  = 3;

    // Line-count width from the maximum number of active lines
    function automatic int calc_lw(input int max_vsize);
        return $clog2(max_vsize) + 1;
    endfunction

    // Pixel-count width from the maximum number of active pixels per line
    function automatic int calc_pw(input int max_hsize);
        return $clog2(max_hsize) + 1;
    endfunction

endpackage : vid_dbg_pkg
`default_nettype wire

// File: rtl/vid_dbg_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vid_dbg_capture_ctrl
// Description : Run controller for the frame-size error checker. Holds the
//               checker in reset until armed, flushes it, releases it aligned
//               to a start-of-frame beat, monitors a programmed number of
//               frames and snapshots the stream position and error code of
//               the first error seen.
// Ports       : aclk/resetn      - clock, asynchronous active-low reset
//               arm/abort        - run control pulses
//               stop_on_err      - stop at first error when set
//               num_frames       - frames to monitor (0 = unlimited)
//               sof, err_vec     - stream SOF beat and checker error flags
//               frame/line/pixel_cnt - stream position for the snapshot
//               checker_resetn   - registered reset for the checker
//               state/busy/done  - run status
//               triggered, err_cnt, frames_done, snap_* - run results
// Revision    : 1.0 - initial release
// ============================================================================
module vid_dbg_capture_ctrl
    import vid_dbg_pkg::*;
#(
    parameter int MAX_HSIZE    = 1920,
    parameter int MAX_VSIZE    = 1080,
    parameter int FLUSH_CYCLES = 4,
    parameter int ERR_CNT_W    = 16,
    localparam int LW          = calc_lw(MAX_VSIZE),
    localparam int PW          = calc_pw(MAX_HSIZE)
) (
    input  logic                 aclk,
    input  logic                 resetn,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 stop_on_err,
    input  logic [31:0]          num_frames,
    input  logic                 sof,
    input  logic [3:0]           err_vec,
    input  logic [31:0]          frame_cnt,
    input  logic [LW-1:0]        line_cnt,
    input  logic [PW-1:0]        pixel_cnt,
    output logic                 checker_resetn,
    output logic [2:0]           state,
    output logic                 busy,
    output logic                 done,
    output logic                 triggered,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [31:0]          frames_done,
    output logic [31:0]          snap_frame,
    output logic [LW-1:0]        snap_line,
    output logic [PW-1:0]        snap_pixel,
    output logic [3:0]           snap_code
);

    localparam int              c_FW         = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [c_FW-1:0] c_FLUSH_LOAD = c_FW'(FLUSH_CYCLES - 1);

    logic [2:0]           r_state,          w_state_nxt;
    logic [c_FW-1:0]      r_flush_cnt,      w_flush_cnt_nxt;
    logic                 r_checker_resetn, w_checker_resetn_nxt;
    logic                 r_busy,           w_busy_nxt;
    logic                 r_done,           w_done_nxt;
    logic                 r_triggered,      w_triggered_nxt;
    logic [ERR_CNT_W-1:0] r_err_cnt,        w_err_cnt_nxt;
    logic [31:0]          r_frames_done,    w_frames_done_nxt;
    logic [31:0]          r_snap_frame,     w_snap_frame_nxt;
    logic [LW-1:0]        r_snap_line,      w_snap_line_nxt;
    logic [PW-1:0]        r_snap_pixel,     w_snap_pixel_nxt;
    logic [3:0]           r_snap_code,      w_snap_code_nxt;

    logic                 w_err_hit;
    logic [31:0]          w_frames_inc;
    logic                 w_cur_released;
    logic                 w_nxt_released;

    // The checker is still in reset on the first MONITOR cycle (its resetn is
    // registered one cycle behind the state), so its flags are not trusted
    // until checker_resetn is actually high.
    assign w_err_hit    = (r_state == ST_MONITOR) && r_checker_resetn && (err_vec != 4'd0);
    assign w_frames_inc = r_frames_done + 32'd1;

    always_comb begin
        w_state_nxt       = r_state;
        w_flush_cnt_nxt   = r_flush_cnt;
        w_triggered_nxt   = r_triggered;
        w_err_cnt_nxt     = r_err_cnt;
        w_frames_done_nxt = r_frames_done;
        w_snap_frame_nxt  = r_snap_frame;
        w_snap_line_nxt   = r_snap_line;
        w_snap_pixel_nxt  = r_snap_pixel;
        w_snap_code_nxt   = r_snap_code;

        if (abort) begin
            // Status is deliberately kept so software can read it after abort
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_TRIGGERED, ST_DONE: begin
                    if (arm) begin
                        w_state_nxt       = ST_FLUSH;
                        w_flush_cnt_nxt   = c_FLUSH_LOAD;
                        w_triggered_nxt   = 1'b0;
                        w_err_cnt_nxt     = '0;
                        w_frames_done_nxt = '0;
                        w_snap_frame_nxt  = '0;
                        w_snap_line_nxt   = '0;
                        w_snap_pixel_nxt  = '0;
                        w_snap_code_nxt   = '0;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        w_state_nxt = ST_WAIT_SOF;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - c_FW'(1);
                    end
                end
                ST_WAIT_SOF: begin
                    // This SOF opens frame 1; it is not a completed frame
                    if (sof) begin
                        w_state_nxt = ST_MONITOR;
                    end
                end
                ST_MONITOR: begin
                    if (sof) begin
                        w_frames_done_nxt = w_frames_inc;
                        if ((num_frames != 32'd0) && (w_frames_inc == num_frames)) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                    // Error handling follows the frame count so that a
                    // stop-on-error overrides a coincident final-frame DONE.
                    if (w_err_hit) begin
                        if (r_err_cnt != '1) begin
                            w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
                        end
                        if (!r_triggered) begin
                            w_triggered_nxt  = 1'b1;
                            w_snap_frame_nxt = frame_cnt;
                            w_snap_line_nxt  = line_cnt;
                            w_snap_pixel_nxt = pixel_cnt;
                            w_snap_code_nxt  = err_vec;
                        end
                        if (stop_on_err) begin
                            w_state_nxt = ST_TRIGGERED;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Release the checker only once the controller has already spent a cycle
    // in a released state; this delays the rise by one cycle after entering
    // MONITOR while dropping it together with any exit to IDLE/FLUSH.
    assign w_cur_released = (r_state == ST_MONITOR) || (r_state == ST_TRIGGERED) ||
                            (r_state == ST_DONE);
    assign w_nxt_released = (w_state_nxt == ST_MONITOR) || (w_state_nxt == ST_TRIGGERED) ||
                            (w_state_nxt == ST_DONE);
    assign w_checker_resetn_nxt = w_cur_released && w_nxt_released;

    assign w_busy_nxt = (w_state_nxt == ST_FLUSH) || (w_state_nxt == ST_WAIT_SOF) ||
                        (w_state_nxt == ST_MONITOR);
    assign w_done_nxt = (w_state_nxt == ST_DONE);

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_state          <= ST_IDLE;
            r_flush_cnt      <= '0;
            r_checker_resetn <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_triggered      <= 1'b0;
            r_err_cnt        <= '0;
            r_frames_done    <= '0;
            r_snap_frame     <= '0;
            r_snap_line      <= '0;
            r_snap_pixel     <= '0;
            r_snap_code      <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_flush_cnt      <= w_flush_cnt_nxt;
            r_checker_resetn <= w_checker_resetn_nxt;
            r_busy           <= w_busy_nxt;
            r_done           <= w_done_nxt;
            r_triggered      <= w_triggered_nxt;
            r_err_cnt        <= w_err_cnt_nxt;
            r_frames_done    <= w_frames_done_nxt;
            r_snap_frame     <= w_snap_frame_nxt;
            r_snap_line      <= w_snap_line_nxt;
            r_snap_pixel     <= w_snap_pixel_nxt;
            r_snap_code      <= w_snap_code_nxt;
        end
    end

    assign checker_resetn = r_checker_resetn;
    assign state          = r_state;
    assign busy           = r_busy;
    assign done           = r_done;
    assign triggered      = r_triggered;
    assign err_cnt        = r_err_cnt;
    assign frames_done    = r_frames_done;
    assign snap_frame     = r_snap_frame;
    assign snap_line      = r_snap_line;
    assign snap_pixel     = r_snap_pixel;
    assign snap_code      = r_snap_code;

endmodule : vid_dbg_capture_ctrl
`default_nettype wire

// File: tb/tb_vid_dbg_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vid_dbg_capture_ctrl
// Description : Directed self-checking bench for vid_dbg_capture_ctrl.
//               Inputs change 1 ns after the rising edge; outputs are
//               checked at that same point, away from the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vid_dbg_capture_ctrl;

    localparam int LW = 12;
    localparam int PW = 12;

    logic          aclk;
    logic          resetn;
    logic          arm;
    logic          abort;
    logic          stop_on_err;
    logic [31:0]   num_frames;
    logic          sof;
    logic [3:0]    err_vec;
    logic [31:0]   frame_cnt;
    logic [LW-1:0] line_cnt;
    logic [PW-1:0] pixel_cnt;
    logic          checker_resetn;
    logic [2:0]    state;
    logic          busy;
    logic          done;
    logic          triggered;
    logic [15:0]   err_cnt;
    logic [31:0]   frames_done;
    logic [31:0]   snap_frame;
    logic [LW-1:0] snap_line;
    logic [PW-1:0] snap_pixel;
    logic [3:0]    snap_code;

    int n_tests;
    int n_fail;

    vid_dbg_capture_ctrl #(
        .MAX_HSIZE    (1920),
        .MAX_VSIZE    (1080),
        .FLUSH_CYCLES (4),
        .ERR_CNT_W    (16)
    ) u_dut (
        .aclk           (aclk),
        .resetn         (resetn),
        .arm            (arm),
        .abort          (abort),
        .stop_on_err    (stop_on_err),
        .num_frames     (num_frames),
        .sof            (sof),
        .err_vec        (err_vec),
        .frame_cnt      (frame_cnt),
        .line_cnt       (line_cnt),
        .pixel_cnt      (pixel_cnt),
        .checker_resetn (checker_resetn),
        .state          (state),
        .busy           (busy),
        .done           (done),
        .triggered      (triggered),
        .err_cnt        (err_cnt),
        .frames_done    (frames_done),
        .snap_frame     (snap_frame),
        .snap_line      (snap_line),
        .snap_pixel     (snap_pixel),
        .snap_code      (snap_code)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        step();
        sof = 1'b0;
    endtask

    // arm -> 4 FLUSH cycles -> WAIT_SOF -> sof; returns on the first MONITOR cycle
    task automatic enter_monitor();
        pulse_arm();
        repeat (4) step();
        pulse_sof();
    endtask

    task automatic err_at(input logic [3:0] code, input logic [31:0] f,
                          input logic [LW-1:0] l, input logic [PW-1:0] p);
        err_vec   = code;
        frame_cnt = f;
        line_cnt  = l;
        pixel_cnt = p;
        step();
        err_vec   = 4'd0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        resetn      = 1'b0;
        arm         = 1'b0;
        abort       = 1'b0;
        stop_on_err = 1'b0;
        num_frames  = 32'd3;
        sof         = 1'b0;
        err_vec     = 4'd0;
        frame_cnt   = 32'd0;
        line_cnt    = '0;
        pixel_cnt   = '0;

        repeat (3) step();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_chk_rstn", {31'd0, checker_resetn}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        resetn = 1'b1;
        step();

        // ---------------- Basic run ----------------
        pulse_arm();
        check("basic_flush", {29'd0, state}, 32'd1);
        check("basic_busy", {31'd0, busy}, 32'd1);
        repeat (3) step();
        check("basic_flush_hold", {29'd0, state}, 32'd1);
        step();
        check("basic_wait_sof", {29'd0, state}, 32'd2);
        check("basic_chk_rstn_wait", {31'd0, checker_resetn}, 32'd0);
        pulse_sof();
        check("basic_monitor", {29'd0, state}, 32'd3);
        check("basic_chk_rstn_first", {31'd0, checker_resetn}, 32'd0);
        check("basic_frames_0", frames_done, 32'd0);
        step();
        check("basic_chk_rstn_up", {31'd0, checker_resetn}, 32'd1);
        pulse_sof();
        step();
        pulse_sof();
        check("basic_frames_2", frames_done, 32'd2);
        check("basic_still_mon", {29'd0, state}, 32'd3);
        step();
        pulse_sof();
        check("basic_done_state", {29'd0, state}, 32'd5);
        check("basic_done_flag", {30'd0, busy, done}, 32'd1);
        check("basic_frames_3", frames_done, 32'd3);
        check("basic_trig", {31'd0, triggered}, 32'd0);
        check("basic_done_chk_rstn", {31'd0, checker_resetn}, 32'd1);

        // ---------------- Stop on error ----------------
        stop_on_err = 1'b1;
        num_frames  = 32'd0;
        enter_monitor();
        step();
        err_at(4'b0010, 32'd7, 12'd12, 12'd1919);
        check("soe_state", {29'd0, state}, 32'd4);
        check("soe_snap_frame", snap_frame, 32'd7);
        check("soe_snap_line", {20'd0, snap_line}, 32'd12);
        check("soe_snap_pixel", {20'd0, snap_pixel}, 32'd1919);
        check("soe_snap_code", {28'd0, snap_code}, 32'h2);
        check("soe_err_cnt", {16'd0, err_cnt}, 32'd1);
        check("soe_trig", {31'd0, triggered}, 32'd1);
        err_at(4'b0001, 32'd9, 12'd1, 12'd1);
        check("soe_hold_state", {29'd0, state}, 32'd4);
        check("soe_hold_cnt", {16'd0, err_cnt}, 32'd1);
        check("soe_chk_rstn", {31'd0, checker_resetn}, 32'd1);

        // ---------------- Continue on error ----------------
        stop_on_err = 1'b0;
        pulse_arm();
        check("rearm_err_cnt", {16'd0, err_cnt}, 32'd0);
        check("rearm_trig", {31'd0, triggered}, 32'd0);
        check("rearm_snap", {28'd0, snap_code}, 32'd0);
        check("rearm_snap_frame", snap_frame, 32'd0);
        repeat (4) step();
        pulse_sof();
        step();
        err_at(4'b0001, 32'd1, 12'd2, 12'd3);
        step();
        err_at(4'b0100, 32'd1, 12'd5, 12'd6);
        err_at(4'b1000, 32'd2, 12'd7, 12'd8);
        step();
        err_at(4'b0011, 32'd3, 12'd9, 12'd10);
        err_at(4'b1111, 32'd4, 12'd11, 12'd12);
        check("coe_err_cnt", {16'd0, err_cnt}, 32'd5);
        check("coe_state", {29'd0, state}, 32'd3);
        check("coe_snap_code", {28'd0, snap_code}, 32'h1);
        check("coe_snap_pos", {snap_frame[7:0], snap_line, snap_pixel}, {8'd1, 12'd2, 12'd3});

        // ---------------- Abort ----------------
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_state", {29'd0, state}, 32'd0);
        check("abort_chk_rstn", {31'd0, checker_resetn}, 32'd0);
        check("abort_err_cnt", {16'd0, err_cnt}, 32'd5);
        check("abort_busy", {31'd0, busy}, 32'd0);

        // ---------------- Simultaneous error and last sof ----------------
        num_frames = 32'd2;
        enter_monitor();
        step();
        pulse_sof();
        sof = 1'b1;
        err_at(4'b1000, 32'd2, 12'd0, 12'd0);
        sof = 1'b0;
        check("sim_nosoe_state", {29'd0, state}, 32'd5);
        check("sim_nosoe_err_cnt", {16'd0, err_cnt}, 32'd1);
        check("sim_nosoe_frames", frames_done, 32'd2);
        check("sim_nosoe_code", {28'd0, snap_code}, 32'h8);

        stop_on_err = 1'b1;
        enter_monitor();
        step();
        pulse_sof();
        sof = 1'b1;
        err_at(4'b1000, 32'd2, 12'd0, 12'd0);
        sof = 1'b0;
        check("sim_soe_state", {29'd0, state}, 32'd4);
        check("sim_soe_frames", frames_done, 32'd2);

        // arm and abort together: abort wins
        arm   = 1'b1;
        abort = 1'b1;
        step();
        arm   = 1'b0;
        abort = 1'b0;
        check("armabort_state", {29'd0, state}, 32'd0);
        check("armabort_err_cnt", {16'd0, err_cnt}, 32'd1);

        // ---------------- Startup error masking ----------------
        num_frames = 32'd0;
        enter_monitor();
        err_at(4'b1111, 32'd5, 12'd5, 12'd5);
        check("mask_state", {29'd0, state}, 32'd3);
        check("mask_err_cnt", {16'd0, err_cnt}, 32'd0);
        check("mask_trig", {31'd0, triggered}, 32'd0);
        check("mask_chk_rstn", {31'd0, checker_resetn}, 32'd1);

        // ---------------- Error counter saturation ----------------
        stop_on_err = 1'b0;
        err_vec = 4'b0001;
        repeat (65535) step();
        check("sat_full", {16'd0, err_cnt}, 32'h0000_FFFF);
        step();
        err_vec = 4'd0;
        check("sat_hold", {16'd0, err_cnt}, 32'h0000_FFFF);

        // ---------------- Async reset mid-MONITOR ----------------
        sof = 1'b1;
        step();
        sof = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("arst_state", {29'd0, state}, 32'd0);
        check("arst_chk_rstn", {31'd0, checker_resetn}, 32'd0);
        check("arst_err_cnt", {16'd0, err_cnt}, 32'd0);
        check("arst_flags", {29'd0, busy, done, triggered}, 32'd0);
        check("arst_frames", frames_done, 32'd0);
        check("arst_snap", {snap_code, snap_line, snap_pixel}, 32'd0);
        step();
        resetn = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_vid_dbg_capture_ctrl
`default_nettype wire
